// File: rtl/r2b_row_packer.sv
// Packs IN_WORDS-element input beats into one COL-element row and pulses each completed row
// to the row-to-block converter. Stops after ROW rows and flags s_last framing errors.
module r2b_row_packer #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int COL        = 256,
    parameter int ROW        = 2754,
    parameter int IN_WORDS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH*IN_WORDS-1:0] s_data,
    input  logic                      s_last,
    output logic                      out_valid,
    output logic [WIDTH*COL-1:0]      out_data,
    output logic [$clog2(ROW)-1:0]    out_row_idx,
    output logic                      done,
    output logic                      err
);

    localparam int BEATS_PER_ROW = COL / IN_WORDS;
    localparam int BEAT_W        = WIDTH * IN_WORDS;
    localparam int ROW_W         = WIDTH * COL;
    localparam int BCNT_W        = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int RCNT_W        = $clog2(ROW + 1);
    localparam int IDX_W         = $clog2(ROW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PACK = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // FRAC_WIDTH only travels with the data; it is checked here so that it is not silently bogus.
    if ((COL % IN_WORDS) != 0 || FRAC_WIDTH > WIDTH) begin : g_bad_params
        $error("r2b_row_packer: COL must be a multiple of IN_WORDS and FRAC_WIDTH <= WIDTH");
    end

    logic [1:0]        state_q, state_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [RCNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]  asm_q, asm_d;
    logic              valid_d;
    logic [ROW_W-1:0]  data_d;
    logic [IDX_W-1:0]  idx_d;
    logic              done_d;
    logic              err_d;

    logic hs;
    logic last_beat;
    logic last_row;

    assign s_ready   = (state_q == PACK) && en;
    assign hs        = s_valid && s_ready;
    assign last_beat = (beat_cnt_q == BCNT_W'(BEATS_PER_ROW - 1));
    assign last_row  = (row_cnt_q == RCNT_W'(ROW - 1));

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        asm_d      = asm_q;
        valid_d    = 1'b0;
        data_d     = out_data;
        idx_d      = out_row_idx;
        done_d     = done;
        err_d      = err;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                if (hs) begin
                    if (s_last && !(last_beat && last_row)) begin
                        // Premature end of matrix: drop the partial row and stop.
                        err_d      = 1'b1;
                        done_d     = 1'b1;
                        state_d    = DONE;
                        beat_cnt_d = '0;
                    end else begin
                        for (int b = 0; b < BEATS_PER_ROW; b++) begin
                            if (beat_cnt_q == BCNT_W'(b)) begin
                                asm_d[ROW_W-1-b*BEAT_W -: BEAT_W] = s_data;
                            end
                        end
                        if (last_beat) begin
                            data_d     = asm_d;
                            valid_d    = 1'b1;
                            idx_d      = row_cnt_q[IDX_W-1:0];
                            beat_cnt_d = '0;
                            row_cnt_d  = row_cnt_q + RCNT_W'(1);
                            if (last_row) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                if (!s_last) begin
                                    err_d = 1'b1;
                                end
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
            asm_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_row_idx <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            row_cnt_q   <= row_cnt_d;
            asm_q       <= asm_d;
            out_valid   <= valid_d;
            out_data    <= data_d;
            out_row_idx <= idx_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_r2b_row_packer.sv
// Randomised bench for r2b_row_packer: an element-level model of the row/matrix framing is
// compared against the DUT every cycle, with a few literal expectations pinning the model.
module tb_r2b_row_packer;

    localparam int WIDTH    = 16;
    localparam int COL      = 8;
    localparam int ROW      = 4;
    localparam int IN_WORDS = 2;
    localparam int BPR      = COL / IN_WORDS;
    localparam int DW       = WIDTH * IN_WORDS;
    localparam int RW       = WIDTH * COL;
    localparam int IDXW     = $clog2(ROW);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready;
    logic            out_valid;
    logic [RW-1:0]   out_data;
    logic [IDXW-1:0] out_row_idx;
    logic            done;
    logic            err;

    r2b_row_packer #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (8),
        .COL        (COL),
        .ROW        (ROW),
        .IN_WORDS   (IN_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row_idx (out_row_idx),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Model: matrix is a sequence of accepted beats; every BPR beats form a row of elements.
    bit              m_started = 0;
    bit              m_finished = 0;
    bit              m_err = 0;
    bit              m_valid = 0;
    int              m_beat = 0;
    int              m_row = 0;
    int              m_idx = 0;
    logic [RW-1:0]   m_data = '0;
    logic [WIDTH-1:0] m_elem [COL];

    always @(posedge clk) begin
        bit final_beat;
        m_valid = 0;
        if (rst) begin
            m_started = 0; m_finished = 0; m_err = 0;
            m_beat = 0; m_row = 0; m_idx = 0; m_data = '0;
            for (int j = 0; j < COL; j++) m_elem[j] = '0;
        end else if (!m_started) begin
            if (en) m_started = 1;
        end else if (!m_finished && en && s_valid) begin
            final_beat = (m_row == ROW - 1) && (m_beat == BPR - 1);
            if (s_last && !final_beat) begin
                m_err = 1; m_finished = 1; m_beat = 0;
            end else begin
                for (int w = 0; w < IN_WORDS; w++)
                    m_elem[m_beat*IN_WORDS + w] = s_data[WIDTH*(IN_WORDS-w)-1 -: WIDTH];
                m_beat++;
                if (m_beat == BPR) begin
                    for (int j = 0; j < COL; j++) m_data[RW-1-j*WIDTH -: WIDTH] = m_elem[j];
                    m_idx = m_row; m_valid = 1; m_row++; m_beat = 0;
                    if (m_row == ROW) begin
                        m_finished = 1;
                        if (!s_last) m_err = 1;
                    end
                end
            end
        end
    end

    int            p_t[$];
    int            p_idx[$];
    bit            p_done[$];
    logic [RW-1:0] p_data[$];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("s_ready", RW'(s_ready), RW'(m_started && !m_finished && en));
            chk("out_valid", RW'(out_valid), RW'(m_valid));
            chk("out_data", out_data, m_data);
            chk("out_row_idx", RW'(out_row_idx), RW'(m_idx));
            chk("done", RW'(done), RW'(m_finished));
            chk("err", RW'(err), RW'(m_err));
            if (out_valid) begin
                p_t.push_back(cyc);
                p_idx.push_back(int'(out_row_idx));
                p_done.push_back(done);
                p_data.push_back(out_data);
            end
        end
    end

    // Called at posedge+1; inputs hold across the next posedge, acceptance sampled at negedge.
    task automatic drive(input logic v, input logic e, input logic [DW-1:0] d, input logic l,
                         output bit acc);
        s_valid = v; en = e; s_data = d; s_last = l;
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        bit acc;
        int tries;
        tries = 0;
        acc = 0;
        while (!acc && tries < 20) begin
            drive(1'b1, 1'b1, d, l, acc);
            tries++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout at cycle %0d: got no accept, want accept", cyc);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive(1'b0, 1'b1, '0, 1'b0, acc);
    endtask

    task automatic do_reset();
        bit acc;
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, '0, 1'b0, acc);
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int base, input int b);
        return {16'(base + 2*b + 1), 16'(base + 2*b + 2)};
    endfunction

    initial begin
        int  base;
        bit  acc;
        int  mode;
        int  early;
        logic [RW-1:0] row0_ref;
        logic [RW-1:0] row1_ref;
        logic [RW-1:0] rowa_ref;

        row0_ref = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        row1_ref = 128'h0009_000a_000b_000c_000d_000e_000f_0010;
        rowa_ref = 128'ha000_a001_a002_a003_a004_a005_a006_a007;

        #1;
        do_reset();
        chk_on = 1'b1;

        // Full matrix; en drops for 3 cycles inside the second row.
        base = p_t.size();
        for (int b = 0; b < ROW*BPR; b++) begin
            if (b == 6) repeat (3) drive(1'b1, 1'b0, pat(0, b), 1'b0, acc);
            send_beat(pat(0, b), b == ROW*BPR - 1);
        end
        idle(3);
        chk("m1_pulse_count", RW'(p_t.size() - base), RW'(4));
        if (p_t.size() - base == 4) begin
            chk("m1_row0_data", p_data[base], row0_ref);
            chk("m1_row1_data", p_data[base+1], row1_ref);
            for (int r = 0; r < 4; r++) chk("m1_row_idx", RW'(p_idx[base+r]), RW'(r));
            chk("m1_gap_delay", RW'(p_t[base+1] - p_t[base]), RW'(7));
            chk("m1_spacing2", RW'(p_t[base+2] - p_t[base+1]), RW'(4));
            chk("m1_spacing3", RW'(p_t[base+3] - p_t[base+2]), RW'(4));
            chk("m1_done_row2", RW'(p_done[base+2]), RW'(0));
            chk("m1_done_row3", RW'(p_done[base+3]), RW'(1));
        end
        @(negedge clk);
        chk("m1_err", RW'(err), RW'(0));
        chk("m1_done", RW'(done), RW'(1));
        chk("m1_ready_after", RW'(s_ready), RW'(0));
        @(posedge clk); #1;

        // Early s_last on beat 6 (row 1, second beat).
        do_reset();
        base = p_t.size();
        for (int b = 0; b < 6; b++) send_beat(pat(0, b), b == 5);
        idle(2);
        chk("early_pulse_count", RW'(p_t.size() - base), RW'(1));
        @(negedge clk);
        chk("early_err", RW'(err), RW'(1));
        chk("early_done", RW'(done), RW'(1));
        chk("early_ready", RW'(s_ready), RW'(0));
        @(posedge clk); #1;

        // Missing s_last on the final beat.
        do_reset();
        base = p_t.size();
        for (int b = 0; b < ROW*BPR; b++) send_beat(pat(0, b), 1'b0);
        idle(2);
        chk("nolast_pulse_count", RW'(p_t.size() - base), RW'(4));
        @(negedge clk);
        chk("nolast_err", RW'(err), RW'(1));
        chk("nolast_done", RW'(done), RW'(1));
        @(posedge clk); #1;

        // Reset mid-row, then restart with fresh data.
        do_reset();
        for (int b = 0; b < 6; b++) send_beat(pat(16'h5000, b), 1'b0);
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", RW'(out_valid), RW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_idx", RW'(out_row_idx), RW'(0));
        chk("rst_done", RW'(done), RW'(0));
        chk("rst_err", RW'(err), RW'(0));
        @(posedge clk); #1;
        base = p_t.size();
        for (int b = 0; b < ROW*BPR; b++) send_beat(pat(16'h9fff, b), b == ROW*BPR - 1);
        idle(2);
        chk("restart_pulse_count", RW'(p_t.size() - base), RW'(4));
        if (p_t.size() > base) begin
            chk("restart_idx", RW'(p_idx[base]), RW'(0));
            chk("restart_data", p_data[base], rowa_ref);
        end

        // Randomised matrices with stalls, en drops and framing faults.
        for (int m = 0; m < 10; m++) begin
            do_reset();
            mode  = $urandom_range(0, 3);
            early = $urandom_range(0, ROW*BPR - 2);
            for (int b = 0; b < ROW*BPR; b++) begin
                case ($urandom_range(0, 5))
                    0: drive(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), acc);
                    1: drive(1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), acc);
                    default: ;
                endcase
                if (mode == 1 && b == early) begin
                    send_beat($urandom, 1'b1);
                    break;
                end
                send_beat($urandom, (b == ROW*BPR - 1) ? (mode != 2) : 1'b0);
            end
            idle(3);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
